wb_bus_ctrl: RTL

WB_BUS_CTRL -- requirements
Module: wb_bus_ctrl

---
 rtl/wb_bus_ctrl_pkg.sv | 21 ++
 rtl/wb_bus_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/wb_bus_ctrl_pkg.sv
// Shared types and constants for the Wishbone client-slot bus controller.
// Used by wb_bus_ctrl; see that file for the WB_BUS_CTRL_ERR_CNT_EN option.
package wb_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

  localparam int          SLOT_W                 = 2;
  localparam int          NUM_SLOTS              = 1 << SLOT_W;
  localparam int          DATA_W                 = 32;
  localparam logic [31:0] DEFAULT_READ_VALUE_DEF = 32'hFABDEFAC;

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    slot_onehot       = '0;
    slot_onehot[slot] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_bus_ctrl.sv
// Wishbone bridge-to-client controller: routes one transfer to one of four client slots,
// forces a default ACK on timeout. Define WB_BUS_CTRL_ERR_CNT_EN to add the Err_Cnt_o timeout counter.
module wb_bus_ctrl
  import wb_bus_ctrl_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter logic [31:0] DEFAULT_READ_VALUE = DEFAULT_READ_VALUE_DEF
) (
  input  logic         WB_CLK,
  input  logic         WB_RST,
  input  logic [16:0]  WBs_ADR,
  input  logic         WBs_CYC,
  input  logic         WBs_STB,
  input  logic         WBs_WE,
  output logic         WBs_ACK_o,
  output logic [31:0]  WBs_RD_DAT_o,
  output logic [3:0]   Cli_CYC_o,
  input  logic [3:0]   Cli_ACK_i,
  input  logic [127:0] Cli_RD_DAT_i,
  output logic         Timeout_o
`ifdef WB_BUS_CTRL_ERR_CNT_EN
  ,
  output logic [7:0]   Err_Cnt_o
`endif
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]  cli_cyc_q, cli_cyc_d;
  logic                  ack_q, ack_d;
  logic                  tmo_q, tmo_d;
  logic [DATA_W-1:0]     rd_dat_q, rd_dat_d;

  logic                  sel_ack;
  logic [DATA_W-1:0]     sel_dat;
  logic                  unused_inputs;

  // Write data never passes through here, so WE and the non-slot address bits are intentionally dropped.
  assign unused_inputs = ^{WBs_WE, WBs_ADR[16:14], WBs_ADR[11:0]};

  assign sel_ack = Cli_ACK_i[slot_q];
  assign sel_dat = Cli_RD_DAT_i[{slot_q, 5'b00000} +: DATA_W];

  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      cnt_q     <= '0;
      cli_cyc_q <= '0;
      ack_q     <= 1'b0;
      tmo_q     <= 1'b0;
      rd_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      cli_cyc_q <= cli_cyc_d;
      ack_q     <= ack_d;
      tmo_q     <= tmo_d;
      rd_dat_q  <= rd_dat_d;
    end
  end

  // Priority in ACTIVE: master abort, then client ACK, then timeout; the client wins a same-cycle tie.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    cli_cyc_d = '0;
    ack_d     = 1'b0;
    tmo_d     = 1'b0;
    rd_dat_d  = rd_dat_q;

    case (state_q)
      ST_IDLE: begin
        if (WBs_CYC && WBs_STB && !ack_q) begin
          slot_d    = WBs_ADR[13:12];
          cnt_d     = '0;
          cli_cyc_d = slot_onehot(WBs_ADR[13:12]);
          state_d   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!WBs_CYC) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          rd_dat_d = sel_dat;
          ack_d    = 1'b1;
          state_d  = ST_ACK;
        end else if (cnt_q == TIMEOUT_LIMIT) begin
          rd_dat_d = DEFAULT_READ_VALUE;
          ack_d    = 1'b1;
          tmo_d    = 1'b1;
          state_d  = ST_ACK;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          cli_cyc_d = slot_onehot(slot_q);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign WBs_ACK_o    = ack_q;
  assign WBs_RD_DAT_o = rd_dat_q;
  assign Cli_CYC_o    = cli_cyc_q;
  assign Timeout_o    = tmo_q;

`ifdef WB_BUS_CTRL_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Counts on the same edge that raises Timeout_o, sticking at 255.
  always_ff @(posedge WB_CLK or posedge WB_RST) begin
    if (WB_RST) begin
      err_cnt_q <= '0;
    end else if (tmo_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign Err_Cnt_o = err_cnt_q;
`else
  // No timeout counter in this build.
`endif

endmodule
